cache_refill_ctrl: RTL and testbench

Read-only, direct-mapped cache controller that sequences lookups and line refills for a byte-wide cache sitting between a single requester and a slower backing memory. It owns the tag/valid/data arrays. On a hit it returns the addressed byte. On a miss it fetches the whole line from memory over a valid/ready request channel plus a beat-wise response channel, installs the line, then answers the request. It replaces the free-running, always-enabled cache access with a handshaked, stateful front end.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_line_store.sv | 19 +
 rtl/cache_refill_ctrl.sv | 111 +++++++++++
 tb/tb_cache_refill_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM state type and decoded address layout for the refill controller
package cache_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int LINE_BYTES = 4;
  localparam int NUM_LINES = 16;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND} cache_state_e;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } cache_addr_t;
  function automatic cache_addr_t split_addr(input logic [ADDR_W-1:0] a);
    return cache_addr_t'(a);
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: line data array, one beat-wise write port and one combinational byte read port
module cache_line_store
  import cache_pkg::*;
(
  input  logic              clk_i,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [OFF_W-1:0]  wr_beat,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [OFF_W-1:0]  rd_offset,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [NUM_LINES][LINE_BYTES];
  // refill beats land directly in their byte slot; contents are meaningless until the valid bit is set
  always_ff @(posedge clk_i)
    if (we) mem[wr_index][wr_beat] <= wr_data;
  assign rd_data = mem[rd_index][rd_offset];
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: direct-mapped read-only cache front end with line refill; CACHE_CTRL_STATS_EN adds hit/miss counters
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef CACHE_CTRL_STATS_EN
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
`endif
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rsp_data_i
);
  cache_state_e      state;
  cache_addr_t       addr;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]  tags [NUM_LINES];
  logic [OFF_W-1:0]  beat;
  logic [DATA_W-1:0] rd_data;
  logic              hit, beat_we, last_beat;
  assign hit = valid[addr.index] && tags[addr.index] == addr.tag;
  assign beat_we = state == REFILL_WAIT && mem_rsp_valid_i;
  assign last_beat = beat == OFF_W'(LINE_BYTES - 1);
  // the response pulse cycle is excluded so a new request lands strictly after it
  assign req_ready_o = state == IDLE && !flush_i && !rsp_valid_o;
  cache_line_store u_store (
    .clk_i    (clk_i),
    .we       (beat_we),
    .wr_index (addr.index),
    .wr_beat  (beat),
    .wr_data  (mem_rsp_data_i),
    .rd_index (addr.index),
    .rd_offset(addr.offset),
    .rd_data  (rd_data)
  );
  // tags need no reset: a tag is only consulted behind its valid bit
  always_ff @(posedge clk_i)
    if (beat_we && last_beat) tags[addr.index] <= addr.tag;
  // lookup/refill sequencer; valid is set only on the final beat so an aborted refill leaves the line invalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      addr <= '0;
      valid <= '0;
      beat <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE:
          if (flush_i) valid <= '0;
          else if (req_valid_i && req_ready_o) begin
            addr <= split_addr(req_addr_i);
            state <= LOOKUP;
          end
        LOOKUP:
          if (hit) state <= RESPOND;
          else begin
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o <= {addr.tag, addr.index, {OFF_W{1'b0}}};
            state <= REFILL_REQ;
          end
        REFILL_REQ: begin
          beat <= '0;
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state <= REFILL_WAIT;
          end
        end
        REFILL_WAIT:
          if (mem_rsp_valid_i) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              valid[addr.index] <= 1'b1;
              state <= RESPOND;
            end
          end
        RESPOND: begin
          rsp_valid_o <= 1'b1;
          rsp_data_o <= rd_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CACHE_CTRL_STATS_EN
  // saturating hit/miss tallies, one decision per lookup; flush leaves them alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else if (state == LOOKUP) begin
      if (hit && !(&hit_cnt_o)) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (!hit && !(&miss_cnt_o)) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed table of reads plus flush and mid-refill reset sequences
module tb_cache_refill_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [7:0]  mem_rsp_data_i = '0;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int errors = 0;
  int checks = 0;

  cache_refill_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
`ifdef CACHE_CTRL_STATS_EN
    .hit_cnt_o      (hit_cnt),
    .miss_cnt_o     (miss_cnt),
`endif
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i (mem_rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          stall;
    int          exp_mcyc;
    logic [7:0]  exp_data;
    int          exp_lat;
    logic [31:0] exp_maddr;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // backing memory: line 0 holds 11,22,33,44; every other byte is its low address bits xor 5A
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h11;
      32'h1: return 8'h22;
      32'h2: return 8'h33;
      32'h3: return 8'h44;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // issue one read from a negedge; lat counts negedges after the accepting edge up to the pulse
  task automatic do_read(input logic [31:0] a, input int stall, output logic [7:0] data,
                         output int mcyc, output int lat, output logic [31:0] maddr, output bit stable);
    int w = 0;
    int b = 0;
    int st = stall;
    bit pend = 0;
    bit sending = 0;
    logic [31:0] line;
    line = {a[31:2], 2'b00};
    data = '0; mcyc = 0; lat = 0; maddr = '0; stable = 1;
    req_valid_i = 1'b1;
    req_addr_i = a;
    while (!req_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    check("req_ready", {31'b0, req_ready_o}, 32'h1);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    while (lat < 100) begin
      lat++;
      if (rsp_valid_o) begin
        data = rsp_data_o;
        break;
      end
      if (pend) begin
        sending = 1;
        pend = 0;
      end
      mem_rsp_valid_i = sending && b < 4;
      if (mem_rsp_valid_i) begin
        mem_rsp_data_i = mem_byte(line + 32'(b));
        b++;
      end
      mem_req_ready_i = 1'b0;
      if (mem_req_valid_o) begin
        if (mcyc == 0) maddr = mem_req_addr_o;
        else if (mem_req_addr_o !== maddr) stable = 0;
        mcyc++;
        if (st > 0) st--;
        else begin
          mem_req_ready_i = 1'b1;
          pend = 1;
        end
      end
      @(negedge clk_i);
    end
    mem_rsp_valid_i = 1'b0;
    mem_req_ready_i = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [7:0] data;
    int mcyc, lat;
    logic [31:0] maddr;
    bit stable;
    do_read(v.addr, v.stall, data, mcyc, lat, maddr, stable);
    check({name, " data"}, {24'b0, data}, {24'b0, v.exp_data});
    check({name, " mem_req cycles"}, mcyc, v.exp_mcyc);
    check({name, " latency"}, lat, v.exp_lat);
    if (v.exp_mcyc > 0) begin
      check({name, " mem_req_addr"}, maddr, v.exp_maddr);
      check({name, " addr stable"}, {31'b0, stable}, 32'h1);
    end
    @(negedge clk_i);
    check({name, " pulse width"}, {31'b0, rsp_valid_o}, 32'h0);
  endtask

  initial begin
    int seen;
    int w;
    vecs[0] = '{32'h0000_0000, 0, 1, 8'h11, 8, 32'h0000_0000};
    vecs[1] = '{32'h0000_0002, 0, 0, 8'h33, 3, 32'h0};
    vecs[2] = '{32'h0000_0003, 0, 0, 8'h44, 3, 32'h0};
    vecs[3] = '{32'h0000_0040, 0, 1, 8'h1A, 8, 32'h0000_0040};
    vecs[4] = '{32'h0000_0041, 0, 0, 8'h1B, 3, 32'h0};
    vecs[5] = '{32'h0000_0000, 0, 1, 8'h11, 8, 32'h0000_0000};
    vecs[6] = '{32'h0000_0084, 5, 6, 8'hDE, 13, 32'h0000_0084};
    vecs[7] = '{32'h0000_0087, 0, 0, 8'hDD, 3, 32'h0};
    vecs[8] = '{32'h1234_5679, 2, 3, 8'h23, 10, 32'h1234_5678};
    vecs[9] = '{32'h1234_567B, 0, 0, 8'h21, 3, 32'h0};

    @(negedge clk_i);
    check("reset rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check("reset rsp_data", {24'b0, rsp_data_o}, 32'h0);
    check("reset mem_req_valid", {31'b0, mem_req_valid_o}, 32'h0);
    check("reset mem_req_addr", mem_req_addr_o, 32'h0);
    check("reset req_ready", {31'b0, req_ready_o}, 32'h1);
    flush_i = 1'b1;
    #1 check("reset req_ready flush", {31'b0, req_ready_o}, 32'h0);
    flush_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    flush_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = 32'h2;
    #1 check("flush req_ready", {31'b0, req_ready_o}, 32'h0);
    @(negedge clk_i);
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid_o || mem_req_valid_o) seen = 1;
      @(negedge clk_i);
    end
    check("flush blocks request", seen, 0);
    run_vec("post-flush", '{32'h0000_0002, 0, 1, 8'h33, 8, 32'h0000_0000});

    req_valid_i = 1'b1;
    req_addr_i = 32'h100;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    w = 0;
    while (!mem_req_valid_o && w < 10) begin
      @(negedge clk_i);
      w++;
    end
    check("abort mem_req_valid", {31'b0, mem_req_valid_o}, 32'h1);
    check("abort mem_req_addr", mem_req_addr_o, 32'h100);
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i = 8'hE1;
    @(negedge clk_i);
    mem_rsp_data_i = 8'hE2;
    @(negedge clk_i);
    rst_ni = 1'b0;
    mem_rsp_data_i = 8'hE3;
    #1;
    check("abort rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check("abort rsp_data", {24'b0, rsp_data_o}, 32'h0);
    check("abort mem_req_valid rst", {31'b0, mem_req_valid_o}, 32'h0);
    check("abort mem_req_addr rst", mem_req_addr_o, 32'h0);
    check("abort req_ready", {31'b0, req_ready_o}, 32'h1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_rsp_data_i = 8'hE4;
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    run_vec("post-abort", '{32'h0000_0100, 0, 1, 8'h5A, 8, 32'h0000_0100});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
